// File: rtl/graph_loader.sv
// Graph loader: collects directed edges into an N x N adjacency bitmap and
// derives per-node 1/outdegree weights with a serial restoring divider.
// Optional macro GRAPH_LOADER_SELF_LOOP_EN: keep src==dst edges instead of dropping them.
module graph_loader #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  localparam int IDXW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 edge_valid,
  output logic                 edge_ready,
  input  logic [IDXW-1:0]      edge_src,
  input  logic [IDXW-1:0]      edge_dst,
  input  logic                 edge_last,
  output logic [N*N-1:0]       adjacency,
  output logic [N*WIDTH-1:0]   weights,
  output logic                 busy,
  output logic                 done
);

  localparam int DW        = IDXW + 1;            // holds outdegree 0..N
  localparam int SW        = $clog2(WIDTH + 2);
  localparam int LAST_STEP = WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WEIGHT, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [N-1:0][N-1:0]          adj_q, adj_d;     // [dst][src]
  logic [N-1:0][WIDTH-1:0]      wts_q, wts_d;
  logic [IDXW-1:0]              node_q, node_d;
  logic [SW-1:0]                step_q, step_d;
  logic [DW-1:0]                deg_q, deg_d;
  logic [DW-1:0]                rem_q, rem_d;
  logic [WIDTH-1:0]             quo_q, quo_d;

  logic [DW-1:0]                col_deg;
  logic [DW:0]                  sh;
  logic                         fits;
  logic [WIDTH:0]               quo_full;
  logic [WIDTH-1:0]             weight;
  logic                         self_ok;

  // Column k of the bitmap lists the destinations of node k's out-edges.
  always_comb begin
    col_deg = '0;
    for (int p = 0; p < N; p++)
      col_deg = col_deg + DW'(adj_q[p][node_q]);
  end

  // The dividend 2^WIDTH has a single 1 at its MSB, fed in on the first divide step.
  always_comb begin
    sh       = {rem_q, step_q == SW'(1)};
    fits     = sh >= {1'b0, deg_q};
    quo_full = {quo_q, fits};
    if (deg_q == '0)
      weight = '0;
    else if (quo_full[WIDTH])
      weight = '1;   // only outdegree 1 overflows: saturate just below 1.0
    else
      weight = quo_full[WIDTH-1:0];
  end

  always_comb begin
`ifdef GRAPH_LOADER_SELF_LOOP_EN
    self_ok = 1'b1;
`else
    self_ok = (edge_src != edge_dst);
`endif
  end

  always_comb begin
    state_d = state_q;
    adj_d   = adj_q;
    wts_d   = wts_q;
    node_d  = node_q;
    step_d  = step_q;
    deg_d   = deg_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          adj_d   = '0;
          wts_d   = '0;
          node_d  = '0;
          step_d  = '0;
        end
      end
      S_LOAD: begin
        if (edge_valid) begin
          if (self_ok)
            adj_d[edge_dst][edge_src] = 1'b1;
          if (edge_last)
            state_d = S_WEIGHT;
        end
      end
      S_WEIGHT: begin
        if (step_q == '0) begin
          deg_d  = col_deg;
          rem_d  = '0;
          quo_d  = '0;
          step_d = SW'(1);
        end else begin
          rem_d = fits ? DW'(sh - {1'b0, deg_q}) : sh[DW-1:0];
          quo_d = quo_full[WIDTH-1:0];
          if (step_q == SW'(LAST_STEP)) begin
            step_d        = '0;
            wts_d[node_q] = weight;
            if (node_q == IDXW'(N-1)) begin
              state_d = S_DONE;
              node_d  = '0;
            end else begin
              node_d = node_q + IDXW'(1);
            end
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      adj_q   <= '0;
      wts_q   <= '0;
      node_q  <= '0;
      step_q  <= '0;
      deg_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      adj_q   <= adj_d;
      wts_q   <= wts_d;
      node_q  <= node_d;
      step_q  <= step_d;
      deg_q   <= deg_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
    end
  end

  assign adjacency  = adj_q;
  assign weights    = wts_q;
  assign edge_ready = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WEIGHT);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_graph_loader.sv
// Bench for graph_loader: an edge-set model predicts outputs every cycle,
// directed graphs pin literal results, random graphs exercise the rest.
module tb_graph_loader;
  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int WCYC  = WIDTH + 2;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic        edge_valid = 1'b0, edge_last = 1'b0;
  logic [1:0]  edge_src = '0, edge_dst = '0;
  logic        edge_ready, busy, done;
  logic [15:0] adjacency;
  logic [63:0] weights;

  always #5 clk = ~clk;

  graph_loader #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
    .adjacency(adjacency), .weights(weights), .busy(busy), .done(done)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

`ifdef GRAPH_LOADER_SELF_LOOP_EN
  localparam bit SELF_EN = 1'b1;
`else
  localparam bit SELF_EN = 1'b0;
`endif

  // Model: the graph is a set of edges; a weight appears once its node's time slot ends.
  int               m_mode;       // 0 idle, 1 load, 2 weight, 3 done
  int               m_elapsed;
  bit               m_adj [N*N];
  logic [WIDTH-1:0] m_w [N];

  function automatic logic [WIDTH-1:0] ref_weight(input int deg);
    if (deg == 0) return '0;
    if (deg == 1) return {WIDTH{1'b1}};
    return WIDTH'((1 << WIDTH) / deg);
  endfunction

  function automatic int outdeg(input int k);
    int c = 0;
    for (int p = 0; p < N; p++) c += int'(m_adj[p*N + k]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N*N; i++) m_adj[i] = 1'b0;
    for (int k = 0; k < N; k++) m_w[k] = '0;
  endtask

  logic [15:0] e_adj;
  logic [63:0] e_w;

  initial m_mode = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0;
      model_clear();
    end else begin
      case (m_mode)
        0, 3: if (start) begin m_mode = 1; model_clear(); end
        1: if (edge_valid) begin
          if (SELF_EN || edge_src != edge_dst)
            m_adj[int'(edge_dst)*N + int'(edge_src)] = 1'b1;
          if (edge_last) begin m_mode = 2; m_elapsed = 0; end
        end
        2: begin
          m_elapsed++;
          for (int k = 0; k < N; k++)
            if ((k+1)*WCYC == m_elapsed) m_w[k] = ref_weight(outdeg(k));
          if (m_elapsed == N*WCYC) m_mode = 3;
        end
        default: m_mode = 0;
      endcase
    end
    #1;
    for (int i = 0; i < N*N; i++) e_adj[i] = m_adj[i];
    for (int k = 0; k < N; k++) e_w[k*WIDTH +: WIDTH] = m_w[k];
    chk("edge_ready", 64'(edge_ready), 64'(m_mode == 1));
    chk("busy",       64'(busy),       64'(m_mode == 1 || m_mode == 2));
    chk("done",       64'(done),       64'(m_mode == 3));
    chk("adjacency",  64'(adjacency),  64'(e_adj));
    chk("weights",    weights,         e_w);
  end

  // ---------------- driver ----------------
  logic [1:0] base_s [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [1:0] base_d [8] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2};

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic [1:0] d, input logic last, input int gap);
    int n = 0;
    repeat (gap) begin edge_valid = 1'b0; @(negedge clk); end
    edge_valid = 1'b1; edge_src = s; edge_dst = d; edge_last = last;
    while (!edge_ready && n < 50) begin @(negedge clk); n++; end
    chk("hs_ready", 64'(edge_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_done(input int start_at, output int k);
    k = 0;
    while (!done && k < 300) begin
      start = (k == start_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
  endtask

  task automatic send_base(input int gapmax, input bit dup, input bit hold);
    for (int i = 0; i < 8; i++) begin
      if (dup && i == 0) begin
        send(2'd0, 2'd1, 1'b0, 0);
        send(2'd0, 2'd1, 1'b0, 1);
      end
      send(base_s[i], base_d[i], i == 7, $urandom_range(0, gapmax));
      if (!hold) edge_valid = 1'b0;
    end
    if (hold) begin edge_src = 2'd1; edge_dst = 2'd0; edge_last = 1'b0; end
  endtask

  task automatic check_base(input string tag, input int k);
    chk({tag, "_latency"}, 64'(k),         64'd72);
    chk({tag, "_adj"},     64'(adjacency), 64'h3B1C);
    chk({tag, "_w"},       weights,        64'h8000_FFFF_8000_5555);
  endtask

  initial begin
    int k;
    int ne;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_adj",   64'(adjacency), 64'd0);
    chk("rst_w",     weights,        64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_ready", 64'(edge_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // reference graph
    pulse_start();
    send_base(0, 1'b0, 1'b0);
    wait_done(-1, k);
    check_base("base", k);

    // duplicate 0->1
    pulse_start();
    send_base(1, 1'b1, 1'b0);
    wait_done(-1, k);
    check_base("dup", k);

    // single edge
    pulse_start();
    send(2'd1, 2'd0, 1'b1, 0);
    edge_valid = 1'b0;
    wait_done(-1, k);
    chk("single_adj", 64'(adjacency), 64'h0002);
    chk("single_w",   weights,        64'h0000_0000_FFFF_0000);

    // self loop
    pulse_start();
    send(2'd2, 2'd2, 1'b1, 0);
    edge_valid = 1'b0;
    wait_done(-1, k);
    chk("self_latency", 64'(k), 64'd72);
`ifdef GRAPH_LOADER_SELF_LOOP_EN
    chk("self_adj", 64'(adjacency), 64'h0400);
    chk("self_w",   weights,        64'h0000_FFFF_0000_0000);
`else
    chk("self_adj", 64'(adjacency), 64'h0000);
    chk("self_w",   weights,        64'h0);
`endif

    // reset 10 cycles into WEIGHT
    pulse_start();
    send_base(0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_adj",   64'(adjacency),  64'd0);
    chk("mid_rst_w",     weights,         64'd0);
    chk("mid_rst_busy",  64'(busy),       64'd0);
    chk("mid_rst_done",  64'(done),       64'd0);
    chk("mid_rst_ready", 64'(edge_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    pulse_start();
    send_base(0, 1'b0, 1'b0);
    wait_done(-1, k);
    check_base("resume", k);

    // valid held high: beats offered in DONE and WEIGHT must be ignored; start in WEIGHT too
    edge_valid = 1'b1; edge_src = 2'd1; edge_dst = 2'd0; edge_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("offer_done_adj", 64'(adjacency), 64'h3B1C);
    pulse_start();
    send_base(2, 1'b0, 1'b1);
    wait_done(5, k);
    edge_valid = 1'b0;
    check_base("stall", k);

    // random graphs
    for (int g = 0; g < 4; g++) begin
      pulse_start();
      ne = $urandom_range(1, 12);
      for (int e = 0; e < ne; e++) begin
        send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), e == ne - 1,
             $urandom_range(0, 2));
        edge_valid = 1'b0;
      end
      wait_done(-1, k);
      chk("rand_latency", 64'(k), 64'd72);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/graph_loader.md
GRAPH_LOADER -- requirements
Module: graph_loader

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the node count (power of two, at least 2); IDXW = clog2(N).
REQ-002 The module SHALL have parameter WIDTH, default 16, meaning the weight width in unsigned Q0.WIDTH format.
REQ-003 The module SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port start, input, 1 bit: a single-cycle pulse that begins a new graph load.
REQ-006 The module SHALL have port edge_valid, input, 1 bit: the edge beat is valid.
REQ-007 The module SHALL have port edge_ready, output, 1 bit: the loader accepts an edge beat.
REQ-008 The module SHALL have port edge_src, input, IDXW bits: the source node of a directed edge.
REQ-009 The module SHALL have port edge_dst, input, IDXW bits: the destination node of a directed edge.
REQ-010 The module SHALL have port edge_last, input, 1 bit: marks the final edge of the graph.
REQ-011 The module SHALL have port adjacency, output, N*N bits: bit dst*N+src is set when edge src->dst exists, in the layout the pageRank engine consumes.
REQ-012 The module SHALL have port weights, output, N*WIDTH bits: slice [k*WIDTH +: WIDTH] holds 1/outdegree(k).
REQ-013 The module SHALL have port busy, output, 1 bit: high in the LOAD and WEIGHT states.
REQ-014 The module SHALL have port done, output, 1 bit: high in the DONE state, when adjacency and weights are valid and stable.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, WEIGHT and DONE.
REQ-016 On start in IDLE or DONE, the FSM SHALL enter LOAD at the next edge, clearing adjacency and weights to 0 on that same edge.
REQ-017 start in LOAD or WEIGHT SHALL be ignored.
REQ-018 edge_ready SHALL be 1 only in LOAD and SHALL be a registered/state decode, with no combinational path from edge_valid.
REQ-019 A handshake (edge_valid and edge_ready both high at a rising edge) SHALL set adjacency bit edge_dst*N+edge_src.
REQ-020 A duplicate edge SHALL be idempotent: the bit stays set and the degree is not double-counted.
REQ-021 A handshake with edge_last=1 SHALL apply its edge and move the FSM to WEIGHT on the same edge.
REQ-022 An empty graph SHALL be loaded by a single handshake with edge_last=1, whose edge is applied normally.
REQ-023 WEIGHT SHALL process nodes k=0..N-1 in order, taking exactly 1+(WIDTH+1) cycles per node (18 for WIDTH=16).
REQ-024 The first cycle of each node SHALL latch outdegree(k) = popcount of column k (bits p*N+k, p=0..N-1).
REQ-025 The next WIDTH+1 cycles SHALL run a restoring divider, one quotient bit per cycle, computing floor(2^WIDTH / outdegree).
REQ-026 Weight rules: outdegree 0 -> 0; outdegree 1 -> 2^WIDTH-1 (saturate, 1.0 is unrepresentable); otherwise the divider quotient.
REQ-027 Each weight slice SHALL be written at the end of its node's division; other slices SHALL hold their values.
REQ-028 If the last-edge handshake occurs at edge T, DONE SHALL be entered at edge T+N*(WIDTH+2), so done rises at T+72 for the defaults.
REQ-029 DONE SHALL hold adjacency, weights and done until the next start or reset.
REQ-030 Edge beats offered outside LOAD SHALL be not accepted and SHALL have no effect.

Reset
REQ-031 Asserting reset at any time, including mid-LOAD or mid-WEIGHT, SHALL immediately force IDLE.
REQ-032 Reset SHALL force adjacency=0, weights=0, edge_ready=0, busy=0, done=0, and clear divider and node-counter state.
REQ-033 After reset deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-034 With macro GRAPH_LOADER_SELF_LOOP_EN defined, an edge with src==dst SHALL set its bit and count toward the source node's outdegree.
REQ-035 Without GRAPH_LOADER_SELF_LOOP_EN, an edge with src==dst SHALL still be handshaked (and honour edge_last) but SHALL leave adjacency unchanged; diagonal bits stay 0.

Verification
REQ-036 The bench SHALL cover: reset, start, then edges 0->1, 0->2, 0->3, 1->2, 1->3, 2->0, 3->0, 3->2 (last) -> adjacency=16'h3B1C; weights k0..k3 = 16'h5555, 16'h8000, 16'hFFFF, 16'h8000; done rises 72 cycles after the last handshake.
REQ-037 The bench SHALL cover: the same graph with edge 0->1 sent three times -> identical adjacency and weights (node0 weight still 16'h5555).
REQ-038 The bench SHALL cover: single edge 1->0 with last -> adjacency=16'h0002; weights = 0, 16'hFFFF, 0, 0.
REQ-039 The bench SHALL cover: self-loop 2->2 with last, without the macro -> adjacency=0, all weights 0; with the macro -> adjacency=16'h0400, node2 weight 16'hFFFF.
REQ-040 The bench SHALL cover: reset asserted 10 cycles into WEIGHT -> next cycle all outputs 0, FSM in IDLE; start then resumes normal operation.
REQ-041 The bench SHALL cover: edge_valid held high with randomly stalled beats, plus start pulsed during WEIGHT -> no beats lost, start ignored, results match the first scenario.
